// File: rtl/mmm_pkg.sv
// Shared IFU types: line-queue entry, request FSM states and the line-tag helper.
package mmm_pkg;
    localparam int XLEN           = 32;
    localparam int ILEN           = 32;
    localparam int IFU_LINE_WORDS = 4;
    localparam int IFU_OFFSET     = $clog2(IFU_LINE_WORDS * ILEN / 8);
    localparam int IFU_TAG_W      = XLEN - IFU_OFFSET;
    localparam int IFU_LINE_W     = IFU_LINE_WORDS * ILEN;
    localparam int IFU_WSEL_W     = (IFU_LINE_WORDS > 1) ? $clog2(IFU_LINE_WORDS) : 1;

    typedef struct packed {
        logic                  valid;
        logic [IFU_TAG_W-1:0]  tag;
        logic [IFU_LINE_W-1:0] data;
    } ifu_entry_t;

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} ifu_req_state_t;

    function automatic logic [IFU_TAG_W-1:0] line_tag(input logic [XLEN-1:0] addr);
        return IFU_TAG_W'(addr >> IFU_OFFSET);
    endfunction
endpackage

// File: rtl/ifu_line_lookup.sv
// Combinational tag CAM and word mux over the line queue. With IFU_PREFETCH_EN
// it also reports the hit index and whether line tag+1 is already buffered.
module ifu_line_lookup
    import mmm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  ifu_entry_t            entries_i [DEPTH],
    input  logic [IFU_TAG_W-1:0]  tag_i,
    input  logic [IFU_WSEL_W-1:0] word_sel_i,
    output logic                  hit_o,
    output logic [ILEN-1:0]       word_o
`ifdef IFU_PREFETCH_EN
   ,output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] hit_idx_o,
    output logic                  next_hit_o
`endif
);
    logic [IFU_LINE_WORDS-1:0][ILEN-1:0] hit_line;

    // At most one entry can match, so the last match wins without priority cost.
    always_comb begin
        hit_o    = 1'b0;
        hit_line = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_i[i].valid && entries_i[i].tag == tag_i) begin
                hit_o    = 1'b1;
                hit_line = entries_i[i].data;
            end
        end
    end

    assign word_o = hit_line[word_sel_i];

`ifdef IFU_PREFETCH_EN
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [IFU_TAG_W-1:0] next_tag;

    assign next_tag = tag_i + IFU_TAG_W'(1);

    always_comb begin
        hit_idx_o  = '0;
        next_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_i[i].valid && entries_i[i].tag == tag_i) begin
                hit_idx_o = PTR_W'(i);
            end
            if (entries_i[i].valid && entries_i[i].tag == next_tag) begin
                next_hit_o = 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/ifu_line_queue.sv
// Fully-associative, FIFO-replaced instruction line queue with a single-outstanding
// i-cache request FSM. Define IFU_PREFETCH_EN to enable sequential next-line prefetch.
module ifu_line_queue
    import mmm_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int LINE_WORDS = IFU_LINE_WORDS  // entry type is shared, keep equal to IFU_LINE_WORDS
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [XLEN-1:0]            pc_i,
    output logic                       fetch_ready_o,
    output logic                       read_req_o,
    output logic [XLEN-1:0]            read_addr_o,
    input  logic                       read_done_i,
    input  logic [LINE_WORDS*ILEN-1:0] cache_line_i,
    input  logic                       issue_ready_i,
    output logic                       issue_valid_o,
    output logic [ILEN-1:0]            instruction_o,
    output logic [XLEN-1:0]            instr_pc_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ifu_entry_t       entries_q [DEPTH];
    ifu_entry_t       entries_d [DEPTH];
    logic [PTR_W-1:0] alloc_q, alloc_d;
    ifu_req_state_t   state_q, state_d;
    logic [XLEN-1:0]  read_addr_q, read_addr_d;
    logic             issue_valid_q, issue_valid_d;
    logic [ILEN-1:0]  instr_q, instr_d;
    logic [XLEN-1:0]  instr_pc_q, instr_pc_d;

    logic [IFU_TAG_W-1:0] pc_tag;
    logic                 hit;
    logic [ILEN-1:0]      hit_word;
    logic                 out_free;
    logic                 capture;

`ifdef IFU_PREFETCH_EN
    logic [PTR_W-1:0] hit_idx;
    logic             next_hit;
    logic             prefetch_go;
`endif

    assign pc_tag = line_tag(pc_i);

    ifu_line_lookup #(.DEPTH(DEPTH)) u_lookup (
        .entries_i  (entries_q),
        .tag_i      (pc_tag),
        .word_sel_i (IFU_WSEL_W'(pc_i >> 2)),
        .hit_o      (hit),
        .word_o     (hit_word)
`ifdef IFU_PREFETCH_EN
       ,.hit_idx_o  (hit_idx),
        .next_hit_o (next_hit)
`endif
    );

`ifdef IFU_PREFETCH_EN
    // Never prefetch into the slot that holds the line currently being executed.
    assign prefetch_go = hit && !next_hit && (DEPTH > 1) && (hit_idx != alloc_q);
`endif

    assign out_free      = !issue_valid_q || issue_ready_i;
    assign capture       = hit && out_free && !flush_i;
    assign fetch_ready_o = flush_i || (hit && out_free);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        read_addr_d = read_addr_q;
        alloc_d     = alloc_q;
        entries_d   = entries_q;
        unique case (state_q)
            IDLE: begin
                if (!hit && !flush_i) begin
                    read_addr_d = {pc_tag, {IFU_OFFSET{1'b0}}};
                    state_d     = WAIT;
                end
`ifdef IFU_PREFETCH_EN
                else if (prefetch_go) begin
                    read_addr_d = {pc_tag + IFU_TAG_W'(1), {IFU_OFFSET{1'b0}}};
                    state_d     = WAIT;
                end
`endif
            end
            WAIT: begin
                if (read_done_i) begin
                    if (!flush_i) begin
                        entries_d[alloc_q] = '{valid: 1'b1, tag: line_tag(read_addr_q), data: cache_line_i};
                        alloc_d = (alloc_q == PTR_W'(DEPTH - 1)) ? '0 : alloc_q + PTR_W'(1);
                    end
                    state_d = IDLE;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (read_done_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        if (flush_i) begin
            issue_valid_d = 1'b0;
        end else if (capture) begin
            issue_valid_d = 1'b1;
            instr_d       = hit_word;
            instr_pc_d    = pc_i;
        end else if (out_free) begin
            issue_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            alloc_q       <= '0;
            read_addr_q   <= '0;
            issue_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            alloc_q       <= alloc_d;
            read_addr_q   <= read_addr_d;
            issue_valid_q <= issue_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    // NOTE: only the valid bits are reset; tag and data are don't-care until valid is set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

    assign read_req_o    = (state_q != IDLE);
    assign read_addr_o   = read_addr_q;
    assign issue_valid_o = issue_valid_q;
    assign instruction_o = instr_q;
    assign instr_pc_o    = instr_pc_q;
endmodule

// File: tb/tb_ifu_line_queue.sv
// Directed bench for ifu_line_queue (DEPTH=2): table-driven issue/stall/flush
// vectors plus hand-written miss, drain, eviction and reset-mid-request sequences.
module tb_ifu_line_queue;
    import mmm_pkg::*;

`ifdef IFU_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_i;
    logic             flush_i;
    logic [31:0]      pc_i;
    logic             fetch_ready_o;
    logic             read_req_o;
    logic [31:0]      read_addr_o;
    logic             read_done_i;
    logic [127:0]     cache_line_i;
    logic             issue_ready_i;
    logic             issue_valid_o;
    logic [31:0]      instruction_o;
    logic [31:0]      instr_pc_o;

    always #5 clk = ~clk;

    ifu_line_queue #(.DEPTH(2), .LINE_WORDS(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .pc_i          (pc_i),
        .fetch_ready_o (fetch_ready_o),
        .read_req_o    (read_req_o),
        .read_addr_o   (read_addr_o),
        .read_done_i   (read_done_i),
        .cache_line_i  (cache_line_i),
        .issue_ready_i (issue_ready_i),
        .issue_valid_o (issue_valid_o),
        .instruction_o (instruction_o),
        .instr_pc_o    (instr_pc_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_for(input logic [31:0] a);
        return a ^ 32'h5EED_0013;
    endfunction

    function automatic logic [127:0] line_for(input logic [31:0] base);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = instr_for(base + 32'(w * 4));
        return l;
    endfunction

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic ir, input logic fl,
                         input logic done, input logic [31:0] base);
        pc_i          = pc;
        issue_ready_i = ir;
        flush_i       = fl;
        read_done_i   = done;
        cache_line_i  = done ? line_for(base) : '0;
        #1;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        ir;
        logic        fl;
        logic        exp_fr;
        logic        exp_v;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        tbl [14];
    logic [31:0] prev_pc;

    initial begin
        prev_pc = PF ? 32'h1010 : 32'h1000;
        tbl[0]  = '{32'h1000, 1'b1, 1'b0, 1'b1, 1'b1, prev_pc};
        tbl[1]  = '{32'h1004, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000};
        tbl[2]  = '{32'h1008, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1004};
        tbl[3]  = '{32'h100C, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1008};
        tbl[4]  = '{32'h1000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100C};
        tbl[5]  = '{32'h1000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100C};
        tbl[6]  = '{32'h1000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100C};
        tbl[7]  = '{32'h1000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100C};
        tbl[8]  = '{32'h1004, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000};
        tbl[9]  = '{32'h1004, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1004};
        tbl[10] = '{32'h1008, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[11] = '{32'h1008, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1008};
        tbl[12] = '{32'h1008, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1008};
        tbl[13] = '{32'h1008, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};

        rst_i = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        next_cycle();
        check("rst_fetch_ready", 32'(fetch_ready_o), 32'd0);
        check("rst_read_req", 32'(read_req_o), 32'd0);
        check("rst_read_addr", read_addr_o, 32'h0);
        check("rst_issue_valid", 32'(issue_valid_o), 32'd0);
        check("rst_instruction", instruction_o, 32'h0);
        check("rst_instr_pc", instr_pc_o, 32'h0);

        // Demand miss on an empty queue.
        rst_i = 1'b0;
        drive(32'h1000, 1'b1, 1'b0, 1'b0, 32'h0);
        check("miss_fetch_ready", 32'(fetch_ready_o), 32'd0);
        next_cycle();
        check("miss_req", 32'(read_req_o), 32'd1);
        check("miss_addr", read_addr_o, 32'h1000);
        next_cycle();
        check("miss_req_hold", 32'(read_req_o), 32'd1);
        next_cycle();
        drive(32'h1000, 1'b1, 1'b0, 1'b1, 32'h1000);
        check("miss_req_at_done", 32'(read_req_o), 32'd1);
        next_cycle();
        drive(32'h1000, 1'b1, 1'b0, 1'b0, 32'h0);
        check("req_drop_after_done", 32'(read_req_o), 32'd0);
        check("fill_hit_ready", 32'(fetch_ready_o), 32'd1);
        check("fill_not_issued_yet", 32'(issue_valid_o), 32'd0);
        next_cycle();
        check("fill_issue_valid", 32'(issue_valid_o), 32'd1);
        check("fill_instruction", instruction_o, instr_for(32'h1000));
        check("fill_instr_pc", instr_pc_o, 32'h1000);
        check("prefetch_req", 32'(read_req_o), 32'(PF));
        if (PF) begin
            check("prefetch_addr", read_addr_o, 32'h1010);
            drive(32'h1000, 1'b1, 1'b0, 1'b1, 32'h1010);
        end
        next_cycle();
        drive(prev_pc, 1'b1, 1'b0, 1'b0, 32'h0);
        check("next_line_hit", 32'(fetch_ready_o), 32'd1);
        check("idle_no_req", 32'(read_req_o), 32'd0);
        next_cycle();

        // Streaming hits, stall, release and flush of the output stage.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].pc, tbl[i].ir, tbl[i].fl, 1'b0, 32'h0);
            check($sformatf("vec%0d_fetch_ready", i), 32'(fetch_ready_o), 32'(tbl[i].exp_fr));
            check($sformatf("vec%0d_issue_valid", i), 32'(issue_valid_o), 32'(tbl[i].exp_v));
            if (tbl[i].exp_v) begin
                check($sformatf("vec%0d_instruction", i), instruction_o, instr_for(tbl[i].exp_pc));
                check($sformatf("vec%0d_instr_pc", i), instr_pc_o, tbl[i].exp_pc);
            end
            next_cycle();
        end

`ifndef IFU_PREFETCH_EN
        // Flush in WAIT: DRAIN discards the late line and alloc_ptr stays put.
        drive(32'h2000, 1'b1, 1'b0, 1'b0, 32'h0);
        check("drain_miss_ready", 32'(fetch_ready_o), 32'd0);
        check("drain_last_issue", instr_pc_o, 32'h1008);
        next_cycle();
        check("drain_req", 32'(read_req_o), 32'd1);
        check("drain_addr", read_addr_o, 32'h2000);
        drive(32'h2000, 1'b1, 1'b1, 1'b0, 32'h0);
        check("flush_ready", 32'(fetch_ready_o), 32'd1);
        next_cycle();
        drive(32'h2000, 1'b1, 1'b0, 1'b0, 32'h0);
        check("drain_req_hold", 32'(read_req_o), 32'd1);
        check("drain_addr_hold", read_addr_o, 32'h2000);
        next_cycle();
        drive(32'h2000, 1'b1, 1'b0, 1'b1, 32'h2000);
        next_cycle();
        drive(32'h2000, 1'b1, 1'b0, 1'b0, 32'h0);
        check("drain_req_drop", 32'(read_req_o), 32'd0);
        check("drain_no_write", 32'(fetch_ready_o), 32'd0);
        next_cycle();
        check("rerequest", 32'(read_req_o), 32'd1);
        check("rerequest_addr", read_addr_o, 32'h2000);
        drive(32'h2000, 1'b1, 1'b0, 1'b1, 32'h2000);
        next_cycle();
        drive(32'h2000, 1'b1, 1'b0, 1'b0, 32'h0);
        check("line2000_hit", 32'(fetch_ready_o), 32'd1);
        next_cycle();

        // Eviction: third line overwrites entry 0 (0x1000), 0x2000 survives.
        drive(32'h3000, 1'b1, 1'b0, 1'b0, 32'h0);
        check("miss3000_ready", 32'(fetch_ready_o), 32'd0);
        check("issue2000_pc", instr_pc_o, 32'h2000);
        check("issue2000_instr", instruction_o, instr_for(32'h2000));
        next_cycle();
        check("miss3000_addr", read_addr_o, 32'h3000);
        drive(32'h3000, 1'b1, 1'b0, 1'b1, 32'h3000);
        next_cycle();
        drive(32'h2000, 1'b1, 1'b0, 1'b0, 32'h0);
        check("evict_2000_still_hits", 32'(fetch_ready_o), 32'd1);
        next_cycle();
        drive(32'h1000, 1'b1, 1'b0, 1'b0, 32'h0);
        check("evict_1000_misses", 32'(fetch_ready_o), 32'd0);
        next_cycle();
        check("refetch_req", 32'(read_req_o), 32'd1);
        check("refetch_addr", read_addr_o, 32'h1000);
        drive(32'h1000, 1'b1, 1'b0, 1'b1, 32'h1000);
        next_cycle();
        drive(32'h1000, 1'b1, 1'b0, 1'b0, 32'h0);
        check("refetch_hit", 32'(fetch_ready_o), 32'd1);
        check("refetch_not_issued", 32'(issue_valid_o), 32'd0);
        next_cycle();
        check("refetch_issue_instr", instruction_o, instr_for(32'h1000));

        // Reset mid-request; a stale response after reset is ignored.
        drive(32'h4000, 1'b1, 1'b0, 1'b0, 32'h0);
        next_cycle();
        check("mid_req", 32'(read_req_o), 32'd1);
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        drive(32'h2000, 1'b1, 1'b1, 1'b1, 32'h2000);
        check("mid_rst_req", 32'(read_req_o), 32'd0);
        check("mid_rst_valid", 32'(issue_valid_o), 32'd0);
        check("mid_rst_addr", read_addr_o, 32'h0);
        next_cycle();
        drive(32'h2000, 1'b1, 1'b0, 1'b0, 32'h0);
        check("post_rst_miss", 32'(fetch_ready_o), 32'd0);
        check("stale_done_ignored", 32'(read_req_o), 32'd0);
        next_cycle();
        check("post_rst_req_addr", read_addr_o, 32'h2000);
        drive(32'h2000, 1'b1, 1'b0, 1'b1, 32'h2000);
        next_cycle();
        drive(32'h2000, 1'b1, 1'b0, 1'b0, 32'h0);
        check("post_rst_hit", 32'(fetch_ready_o), 32'd1);
        next_cycle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ifu_line_queue.md
# ifu_line_queue

Parametrised instruction fetch unit holding up to DEPTH cache lines in a fully-associative, FIFO-replaced line queue between the PC generator and the i-cache interface. Hits on any buffered line issue one instruction per cycle through a registered output stage towards decode. Misses, and optionally sequential next-line prefetches, are fetched through a single-outstanding i-cache request FSM. Flush aborts the in-flight request and kills the output stage.

## Interface
- DEPTH, 4, buffered lines; legal range is 1 to 16.
- LINE_WORDS, 4, ILEN-wide words per line; must be a power of 2. OFFSET = log2(LINE_WORDS*ILEN/8).
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  pipeline flush.
- pc_i  in  XLEN  fetch PC; bits [1:0] are ignored. The PC generator holds it until fetch_ready_o.
- fetch_ready_o  out  1  pc_i is accepted this cycle.
- read_req_o  out  1  i-cache line request (level).
- read_addr_o  out  XLEN  line-aligned request address; low OFFSET bits are 0.
- read_done_i  in  1  response valid for the outstanding request.
- cache_line_i  in  LINE_WORDS*ILEN  response data; word 0 is in the LSBs.
- issue_ready_i  in  1  decode accepts.
- issue_valid_o  out  1  instruction_o/instr_pc_o valid.
- instruction_o  out  ILEN  issued instruction.
- instr_pc_o  out  XLEN  PC of the issued instruction.

## Operation
- Entry: valid, tag = addr[XLEN-1:OFFSET], data. All entries are cleared by rst_i. flush_i does not clear entries; cached code is read-only.
- Lookup: pc_i tag is compared against all valid entries. hit = any match; at most one match exists by construction. Word select = pc_i[OFFSET-1:2].
- Output stage: out_free = !issue_valid_o | issue_ready_i.
  - fetch_ready_o = flush_i | (hit & out_free).
  - On hit & out_free & !flush_i: output register loads the word and pc_i; issue_valid_o = 1 next cycle.
  - With issue_valid_o & !issue_ready_i: output held stable.
- Request FSM states:
  - IDLE.
    - On !hit & !flush_i: read_addr_o = pc_i tag. Go to WAIT.
    - Else, if IFU_PREFETCH_EN is defined and a prefetch is eligible: read_addr_o = (pc_i tag + 1) modulo 2^(XLEN-OFFSET). Go to WAIT.
  - WAIT: read_req_o = 1, read_addr_o stable.
    - On read_done_i: write cache_line_i into entry[alloc_ptr], set valid, alloc_ptr = (alloc_ptr+1) mod DEPTH. Go to IDLE.
    - On flush_i without read_done_i: go to DRAIN.
  - DRAIN: read_req_o = 1. On read_done_i, the data is discarded; go to IDLE.
- Demand miss always has priority over prefetch. Only one request is outstanding at a time.
- Simultaneous events:
  - read_done_i and flush_i in the same cycle: the line is discarded; go to IDLE.
  - flush_i with a hit: fetch_ready_o = 1 but nothing is captured, and issue_valid_o = 0 next cycle.
- Reset mid-request: FSM goes to IDLE, all entries are invalidated, and any later read_done_i is ignored in IDLE.

## Timing
- Reset values:
  - fetch_ready_o, read_req_o, issue_valid_o = 0.
  - read_addr_o, instruction_o, instr_pc_o = 0.
  - alloc_ptr = 0; FSM in IDLE.
- Hit latency: pc_i accepted in cycle t gives issue_valid_o in t+1. Sustained rate is 1 instruction per cycle while hitting and issue_ready_i = 1.
- Miss: detected in t, read_req_o = 1 from t+1. read_done_i in cycle d writes the entry; hit in d+1; issue in d+2.
- read_done_i arrives no earlier than the first cycle read_req_o = 1.
- read_req_o drops in the cycle after read_done_i.
- Tag increment wraps silently. A PC in the top line prefetches line 0.

## Configuration
- IFU_PREFETCH_EN defined: a prefetch is eligible when all of the following hold:
  - FSM is in IDLE.
  - hit = 1.
  - Line tag+1 is absent.
  - DEPTH > 1.
  - entry[alloc_ptr] does not hold the current pc_i line.
- IFU_PREFETCH_EN undefined: requests are issued only on demand misses, and the prefetch logic is absent.

## Structure
- Shared package `mmm_pkg` holds:
  - ifu_entry_t (valid, tag, data).
  - ifu_req_state_t enum {IDLE, WAIT, DRAIN}.
  - Function line_tag(addr).
  - Uses existing XLEN/ILEN.
- One sub-module, `ifu_line_lookup`: combinational tag CAM and word mux. Outputs hit, hit index and selected word; also reports presence of tag+1 for prefetch.
- Top level holds the entry array, alloc_ptr, FSM and output register.

## Test plan
- Reset, then pc_i=0x1000 with an empty queue:
  - read_req_o=1 with read_addr_o=0x1000 in the next cycle.
  - read_done_i 3 cycles later: instruction_o = word 0 and instr_pc_o=0x1000 two cycles after done.
- With the line at 0x1000 buffered, pc_i steps 0x1000 to 0x100C and issue_ready_i=1: four instructions on consecutive cycles and fetch_ready_o=1 throughout.
- issue_ready_i=0 for 3 cycles while issue_valid_o=1: outputs stable and fetch_ready_o=0. Resumes on release with no instruction lost or duplicated.
- flush_i in WAIT with read_done_i 2 cycles later: FSM passes through DRAIN, no entry written, alloc_ptr unchanged, and a new miss is requested after IDLE.
- DEPTH=2 with demand misses at 0x1000, 0x2000, 0x3000: the third response overwrites entry 0, so 0x1000 misses again while 0x2000 still hits.
- With IFU_PREFETCH_EN defined and a hit at 0x1000: request to 0x1010 issued without a demand miss, and pc_i=0x1010 then hits.
- With IFU_PREFETCH_EN undefined and a hit at 0x1000: no request is issued.
